// File: rtl/aes_fifo_pkg.sv
// Widths shared by the AES input/output FIFOs and the AES-128 core.
// Also holds the pointer-advance helper for non-power-of-2 slot counts.
package aes_fifo_pkg;

  localparam int WORD_W = 32;
  localparam int WORDS  = 4;
  localparam int BLK_W  = WORD_W * WORDS;

  typedef logic [BLK_W-1:0] block_t;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Collects bus words into one block; the first word ends up in the top slice.
// The completing word is accepted only when the block store has room.
module fifo_word_packer #(
  parameter int WORD_W = aes_fifo_pkg::WORD_W,
  parameter int WORDS  = aes_fifo_pkg::WORDS,
  parameter int BLK_W  = WORD_W * WORDS,
  parameter int WC_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              blk_space,
  output logic              wr_accept,
  output logic [WC_W-1:0]   word_count,
  output logic              blk_valid,
  output logic [BLK_W-1:0]  blk_data
);

  localparam int ASM_W = (WORDS > 1) ? (WORDS - 1) * WORD_W : WORD_W;

  logic [ASM_W-1:0] asm_q, asm_d;
  logic [ASM_W-1:0] asm_shift;
  logic [WC_W-1:0]  word_count_q, word_count_d;
  logic             last_word;

  generate
    if (WORDS == 1) begin : g_single
      assign blk_data  = wr_data;
      assign asm_shift = asm_q;
    end else if (WORDS == 2) begin : g_pair
      assign blk_data  = {asm_q, wr_data};
      assign asm_shift = wr_data;
    end else begin : g_multi
      assign blk_data  = {asm_q, wr_data};
      assign asm_shift = {asm_q[ASM_W-WORD_W-1:0], wr_data};
    end
  endgenerate

  always_comb begin
    last_word    = (word_count_q == WC_W'(WORDS - 1));
    wr_accept    = wr_en & (~last_word | blk_space);
    blk_valid    = wr_accept & last_word & ~flush;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    if (flush) begin
      asm_d        = '0;
      word_count_d = '0;
    end else if (wr_accept) begin
      if (last_word) begin
        word_count_d = '0;
      end else begin
        asm_d        = asm_shift;
        word_count_d = word_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q        <= '0;
      word_count_q <= '0;
    end else begin
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;

endmodule

// File: rtl/apb_block_fifo.sv
// APB-side input buffer for the AES core: packs words into blocks and queues
// up to DEPTH complete blocks with show-ahead output and error pulses.
module apb_block_fifo #(
  parameter int WORD_W = aes_fifo_pkg::WORD_W,
  parameter int WORDS  = aes_fifo_pkg::WORDS,
  parameter int DEPTH  = 4,
  parameter int BLK_W  = WORD_W * WORDS,
  parameter int BC_W   = $clog2(DEPTH + 1),
  parameter int WC_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BLK_W-1:0]  rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [BC_W-1:0]   blk_count,
  output logic [WC_W-1:0]   word_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BLK_W-1:0] slot_q [DEPTH];
  logic [BLK_W-1:0] slot_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BC_W-1:0]  blk_count_q, blk_count_d;
  logic             fifo_empty_q, fifo_empty_d;
  logic             fifo_full_q, fifo_full_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_accept;
  logic             blk_space;
  logic             wr_accept;
  logic             blk_valid;
  logic [BLK_W-1:0] blk_data;

  fifo_word_packer #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .BLK_W  (BLK_W),
    .WC_W   (WC_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .blk_space  (blk_space),
    .wr_accept  (wr_accept),
    .word_count (word_count),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data)
  );

  always_comb begin
    rd_accept   = rd_en & ~fifo_empty_q;
    // A completing word may use the slot freed by this cycle's pop.
    blk_space   = ~fifo_full_q | rd_accept;
    slot_d      = slot_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    blk_count_d = blk_count_q;

    if (blk_valid) begin
      slot_d[wr_ptr_q] = blk_data;
      wr_ptr_d = PTR_W'(aes_fifo_pkg::wrap_inc(int'(wr_ptr_q), DEPTH));
    end
    if (rd_accept) begin
      rd_ptr_d = PTR_W'(aes_fifo_pkg::wrap_inc(int'(rd_ptr_q), DEPTH));
    end
    case ({blk_valid, rd_accept})
      2'b10:   blk_count_d = blk_count_q + 1'b1;
      2'b01:   blk_count_d = blk_count_q - 1'b1;
      default: blk_count_d = blk_count_q;
    endcase

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      blk_count_d = '0;
    end

    fifo_empty_d = (blk_count_d == '0);
    fifo_full_d  = (blk_count_d == BC_W'(DEPTH));
    overflow_d   = wr_en & ~wr_accept & ~flush;
    underflow_d  = rd_en & fifo_empty_q & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      blk_count_q  <= '0;
      fifo_empty_q <= 1'b1;
      fifo_full_q  <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      blk_count_q  <= blk_count_d;
      fifo_empty_q <= fifo_empty_d;
      fifo_full_q  <= fifo_full_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  always_comb begin
    rd_data = fifo_empty_q ? '0 : slot_q[rd_ptr_q];
  end

  assign fifo_empty = fifo_empty_q;
  assign fifo_full  = fifo_full_q;
  assign blk_count  = blk_count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
